// File: rtl/booth16_mul_ctrl_if.sv
// -----------------------------------------------------------------------------
// booth16_mul_ctrl_if
// Purpose : bundles the request/response handshake and the datapath control
//           strobes of the radix-16 Booth multiplier sequencer.
// Modports:
//   master : requester/datapath side (drives req_*, resp_ready_i, abort_i)
//   slave  : the controller booth16_mul_ctrl
// Signals :
//   req_valid_i / req_signed_i / req_ready_o : operand request handshake
//   load_o, shift_en_o, digit_idx_o, signed_o, final_add_en_o : datapath control
//   resp_valid_o / resp_ready_i             : product handshake
//   abort_i / aborted_o                     : only when MUL_CTRL_ABORT_EN is defined
// Option  : MUL_CTRL_ABORT_EN adds the abort request/acknowledge pair.
// -----------------------------------------------------------------------------
interface booth16_mul_ctrl_if #(
  parameter int WIDTH = 32
);
  localparam int IDX_W = $clog2(WIDTH / 4 + 1);

  logic             req_valid_i;
  logic             req_signed_i;
  logic             req_ready_o;
  logic             load_o;
  logic             shift_en_o;
  logic [IDX_W-1:0] digit_idx_o;
  logic             signed_o;
  logic             final_add_en_o;
  logic             resp_valid_o;
  logic             resp_ready_i;
`ifdef MUL_CTRL_ABORT_EN
  logic             abort_i;
  logic             aborted_o;
`endif

  modport master (
    output req_valid_i, req_signed_i, resp_ready_i,
`ifdef MUL_CTRL_ABORT_EN
    output abort_i,
    input  aborted_o,
`endif
    input  req_ready_o, load_o, shift_en_o, digit_idx_o, signed_o,
           final_add_en_o, resp_valid_o
  );

  modport slave (
    input  req_valid_i, req_signed_i, resp_ready_i,
`ifdef MUL_CTRL_ABORT_EN
    input  abort_i,
    output aborted_o,
`endif
    output req_ready_o, load_o, shift_en_o, digit_idx_o, signed_o,
           final_add_en_o, resp_valid_o
  );
endinterface

// File: rtl/booth16_mul_ctrl.sv
// -----------------------------------------------------------------------------
// booth16_mul_ctrl
// Purpose : sequencing FSM for the radix-16 Booth multiplier datapath.
//           One operand pair per transaction: clear/load the pp/carry shift
//           register, consume one Booth digit per cycle, fire the final add,
//           then hold the result-valid strobe until the consumer accepts it.
// Ports   :
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : booth16_mul_ctrl_if.slave (request, datapath control, response)
// Params  : WIDTH operand width (multiple of 4, >= 8); must match the
//           interface WIDTH and mul_pkg::WIDTH.
// Option  : define MUL_CTRL_ABORT_EN to enable abort_i / aborted_o.
// -----------------------------------------------------------------------------
module booth16_mul_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  booth16_mul_ctrl_if.slave     bus
);

  localparam int DIGITS = WIDTH / 4;
  localparam int IDX_W  = $clog2(DIGITS + 1);

  // Index of the last digit: signed operands need WIDTH/4 digits, unsigned
  // ones one more so the zero sign extension is absorbed.
  localparam logic [IDX_W-1:0] LAST_SIGNED   = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] LAST_UNSIGNED = IDX_W'(DIGITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ITER  = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cnt_next;
  logic             r_signed;
  logic             w_signed_next;
  logic             w_last;
  logic             w_abort_hit;
  logic             r_aborted;

  assign w_last = (r_cnt == (r_signed ? LAST_SIGNED : LAST_UNSIGNED));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_signed  <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_signed  <= w_signed_next;
      r_aborted <= w_abort_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_signed_next = r_signed;
    w_abort_hit   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          w_state_next  = S_LOAD;
          w_signed_next = bus.req_signed_i;
        end
      end
      S_LOAD: begin
        w_state_next = S_ITER;
        w_cnt_next   = '0;
      end
      S_ITER: begin
        // Counter returns to 0 on exit so it never exceeds the last index
        // and digit_idx_o reads 0 outside ITER without extra masking state.
        if (w_last) begin
          w_state_next = S_FINAL;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + IDX_W'(1);
        end
      end
      S_FINAL: begin
        w_state_next = S_DONE;
      end
      S_DONE: begin
        if (bus.resp_ready_i) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase

`ifdef MUL_CTRL_ABORT_EN
    // Abort only cancels work in flight; a finished result in DONE is kept.
    if (bus.abort_i &&
        (r_state == S_LOAD || r_state == S_ITER || r_state == S_FINAL)) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
      w_abort_hit  = 1'b1;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Output decode (all strobes come straight from the state register)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.req_ready_o    = (r_state == S_IDLE);
    bus.load_o         = (r_state == S_LOAD);
    bus.shift_en_o     = (r_state == S_ITER);
    bus.final_add_en_o = (r_state == S_FINAL);
    bus.resp_valid_o   = (r_state == S_DONE);
    bus.digit_idx_o    = (r_state == S_ITER) ? r_cnt : '0;
    bus.signed_o       = r_signed;
  end

`ifdef MUL_CTRL_ABORT_EN
  assign bus.aborted_o = r_aborted;
`else
  // Without the abort option nothing ever sets the acknowledge register.
  logic w_unused_aborted;
  assign w_unused_aborted = r_aborted & w_abort_hit;
`endif

endmodule
